// File: rtl/abuf_sched_pkg.sv
// Shared types and default widths for the activation-buffer read scheduler.
package abuf_sched_pkg;

    localparam int DEF_BUFFER_ADDR_WIDTH = 15;
    localparam int DEF_LEN_WIDTH         = 15;
    localparam int DEF_REP_WIDTH         = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sched_state_t;

endpackage

// File: rtl/abuf_addr_gen.sv
// Tile address generator: holds the latched command, walks idx/rep_cnt and
// forms the wrapped base+idx read address.
module abuf_addr_gen
    import abuf_sched_pkg::*;
#(
    parameter int BUFFER_ADDR_WIDTH = DEF_BUFFER_ADDR_WIDTH,
    parameter int LEN_WIDTH         = DEF_LEN_WIDTH,
    parameter int REP_WIDTH         = DEF_REP_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         load,
    input  logic                         advance,
    input  logic [BUFFER_ADDR_WIDTH-1:0] base,
    input  logic [LEN_WIDTH-1:0]         len,
    input  logic [REP_WIDTH-1:0]         rep,
    output logic [BUFFER_ADDR_WIDTH-1:0] addr,
    output logic                         sweep_end,
    output logic                         cmd_end
);

    logic [BUFFER_ADDR_WIDTH-1:0] base_q;
    logic [LEN_WIDTH-1:0]         len_q;
    logic [REP_WIDTH-1:0]         rep_q;
    logic [LEN_WIDTH-1:0]         idx;
    logic [REP_WIDTH-1:0]         rep_cnt;

    // Latch the command on load, then step idx per read and rep_cnt per sweep.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            base_q  <= '0;
            len_q   <= '0;
            rep_q   <= '0;
            idx     <= '0;
            rep_cnt <= '0;
        end else if (load) begin
            base_q  <= base;
            len_q   <= len;
            rep_q   <= rep;
            idx     <= '0;
            rep_cnt <= '0;
        end else if (advance) begin
            if (sweep_end) begin
                idx     <= '0;
                rep_cnt <= rep_cnt + REP_WIDTH'(1);
            end else begin
                idx <= idx + LEN_WIDTH'(1);
            end
        end
    end

    assign sweep_end = (idx == len_q - LEN_WIDTH'(1));
    assign cmd_end   = sweep_end && (rep_cnt == rep_q - REP_WIDTH'(1));
    assign addr      = base_q + BUFFER_ADDR_WIDTH'(idx);

endmodule

// File: rtl/activation_buffer_rd_sched.sv
// Activation-buffer read sequencer: accepts a tile command and issues one
// read per unpaused cycle, sweeping base..base+len-1 rep times.
module activation_buffer_rd_sched
    import abuf_sched_pkg::*;
#(
    parameter int BUFFER_ADDR_WIDTH = DEF_BUFFER_ADDR_WIDTH,
    parameter int LEN_WIDTH         = DEF_LEN_WIDTH,
    parameter int REP_WIDTH         = DEF_REP_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start_i,
    input  logic [BUFFER_ADDR_WIDTH-1:0] base_addr_i,
    input  logic [LEN_WIDTH-1:0]         len_i,
    input  logic [REP_WIDTH-1:0]         rep_i,
    input  logic                         pause_i,
    output logic                         activation_rd_en_o,
    output logic [BUFFER_ADDR_WIDTH-1:0] buffer_rd_addr_o,
    output logic                         last_o,
    output logic                         busy_o,
    output logic                         done_o
);

    sched_state_t                 state;
    logic                         load;
    logic                         advance;
    logic [BUFFER_ADDR_WIDTH-1:0] gen_addr;
    logic                         sweep_end;
    logic                         cmd_end;

    assign load    = (state == IDLE) && start_i;
    assign advance = (state == RUN) && !pause_i;

    abuf_addr_gen #(
        .BUFFER_ADDR_WIDTH (BUFFER_ADDR_WIDTH),
        .LEN_WIDTH         (LEN_WIDTH),
        .REP_WIDTH         (REP_WIDTH)
    ) u_addr_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .advance   (advance),
        .base      (base_addr_i),
        .len       (len_i),
        .rep       (rep_i),
        .addr      (gen_addr),
        .sweep_end (sweep_end),
        .cmd_end   (cmd_end)
    );

    // Command FSM with registered buffer-facing outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state              <= IDLE;
            activation_rd_en_o <= 1'b0;
            buffer_rd_addr_o   <= '0;
            last_o             <= 1'b0;
            busy_o             <= 1'b0;
            done_o             <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    activation_rd_en_o <= 1'b0;
                    last_o             <= 1'b0;
                    done_o             <= 1'b0;
                    if (start_i) begin
                        busy_o <= 1'b1;
                        if ((len_i == '0) || (rep_i == '0)) begin
                            state <= DONE;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    done_o <= 1'b0;
                    if (pause_i) begin
                        activation_rd_en_o <= 1'b0;
                        last_o             <= 1'b0;
                    end else begin
                        activation_rd_en_o <= 1'b1;
                        buffer_rd_addr_o   <= gen_addr;
                        last_o             <= cmd_end;
                        if (cmd_end) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    activation_rd_en_o <= 1'b0;
                    last_o             <= 1'b0;
                    done_o             <= 1'b1;
                    busy_o             <= 1'b0;
                    state              <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_activation_buffer_rd_sched.sv
// Self-checking bench for activation_buffer_rd_sched against a read-list model.
module tb_activation_buffer_rd_sched;

    localparam int AW = 15;
    localparam int LW = 15;
    localparam int RW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start_i;
    logic [AW-1:0] base_addr_i;
    logic [LW-1:0] len_i;
    logic [RW-1:0] rep_i;
    logic          pause_i;
    logic          activation_rd_en_o;
    logic [AW-1:0] buffer_rd_addr_o;
    logic          last_o;
    logic          busy_o;
    logic          done_o;

    int checks   = 0;
    int failures = 0;

    logic [AW-1:0] addrQ[$];

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    activation_buffer_rd_sched #(
        .BUFFER_ADDR_WIDTH (AW),
        .LEN_WIDTH         (LW),
        .REP_WIDTH         (RW)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .start_i            (start_i),
        .base_addr_i        (base_addr_i),
        .len_i              (len_i),
        .rep_i              (rep_i),
        .pause_i            (pause_i),
        .activation_rd_en_o (activation_rd_en_o),
        .buffer_rd_addr_o   (buffer_rd_addr_o),
        .last_o             (last_o),
        .busy_o             (busy_o),
        .done_o             (done_o)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkAll(input string tag, input logic expRd, input logic [AW-1:0] expAddr,
                            input bit chkAddr, input logic expLast, input logic expBusy,
                            input logic expDone);
        checkOutput({tag, ".rd_en"}, 32'(activation_rd_en_o), 32'(expRd));
        if (chkAddr) checkOutput({tag, ".addr"}, 32'(buffer_rd_addr_o), 32'(expAddr));
        checkOutput({tag, ".last"}, 32'(last_o), 32'(expLast));
        checkOutput({tag, ".busy"}, 32'(busy_o), 32'(expBusy));
        checkOutput({tag, ".done"}, 32'(done_o), 32'(expDone));
    endtask

    task automatic applyStimulus(input logic st, input logic [AW-1:0] b, input logic [LW-1:0] l,
                                 input logic [RW-1:0] r, input logic p);
        start_i     = st;
        base_addr_i = b;
        len_i       = l;
        rep_i       = r;
        pause_i     = p;
    endtask

    task automatic stepEdge();
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycles(input int k);
        for (int i = 0; i < k; i++) begin
            applyStimulus(1'b0, AW'($urandom), LW'($urandom), RW'($urandom), 1'($urandom));
            stepEdge();
            checkAll("idle", 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    // Issue one command from IDLE (or the done cycle) and check every cycle
    // through its done pulse. Reads are the list (base + i mod len) for
    // i = 0 .. len*rep-1; each unpaused edge emits the next list entry.
    task automatic runCommand(input logic [AW-1:0] base, input logic [LW-1:0] len,
                              input logic [RW-1:0] rep, input int pausePct,
                              input int pauseAfter, input bit holdStart);
        int   total;
        int   n;
        int   budget;
        int   pausedDirected;
        logic p;
        total = int'(len) * int'(rep);
        addrQ.delete();
        for (int i = 0; i < total; i++) addrQ.push_back(AW'(int'(base) + (i % int'(len))));
        applyStimulus(1'b1, base, len, rep, 1'b0);
        stepEdge();
        checkAll("accept", 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        if (holdStart) applyStimulus(1'b1, base ^ 15'h5A5A, len + 15'd1, rep, 1'b0);
        else           applyStimulus(1'b0, AW'($urandom), LW'($urandom), RW'($urandom), 1'b0);
        n = 0;
        budget = 0;
        pausedDirected = 0;
        while (n < total && budget < 4 * total + 16) begin
            if (n == pauseAfter && pausedDirected < 2) begin
                p = 1'b1;
                pausedDirected++;
            end else begin
                p = ($urandom_range(99) < pausePct);
            end
            pause_i = p;
            stepEdge();
            budget++;
            if (p) begin
                checkAll("paused", 1'b0, (n > 0) ? addrQ[n > 0 ? n - 1 : 0] : '0, n > 0,
                         1'b0, 1'b1, 1'b0);
            end else begin
                checkAll("read", 1'b1, addrQ[n], 1'b1, n == total - 1, 1'b1, 1'b0);
                n++;
            end
        end
        if (n < total) checkOutput("read_budget", 32'(n), 32'(total));
        start_i = 1'b0;
        pause_i = 1'($urandom);
        stepEdge();
        checkAll("done", 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    // Directed steps followed by randomized commands.
    initial begin
        logic [AW-1:0] abortBase;
        rst_n = 1'b0;
        applyStimulus(1'b0, '0, '0, '0, 1'b0);
        repeat (2) stepEdge();
        checkAll("reset", 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        idleCycles(1);

        $display("[TB] basic sweep");
        runCommand(15'h0010, 15'd4, 8'd2, 0, -1, 1'b0);
        idleCycles(1);

        $display("[TB] pause after third read");
        runCommand(15'h0010, 15'd4, 8'd2, 0, 3, 1'b0);
        idleCycles(1);

        $display("[TB] address wrap");
        runCommand(15'h7FFE, 15'd4, 8'd1, 0, -1, 1'b0);
        idleCycles(1);

        $display("[TB] zero-length commands");
        runCommand(15'h0020, 15'd0, 8'd3, 0, -1, 1'b0);
        idleCycles(1);
        runCommand(15'h0020, 15'd5, 8'd0, 0, -1, 1'b0);
        idleCycles(1);

        $display("[TB] start held during run, then back-to-back restart");
        runCommand(15'h0100, 15'd3, 8'd2, 0, -1, 1'b1);
        runCommand(15'h0200, 15'd2, 8'd2, 0, -1, 1'b0);
        idleCycles(1);

        $display("[TB] reset mid-command");
        abortBase = 15'h0345;
        applyStimulus(1'b1, abortBase, 15'd8, 8'd1, 1'b0);
        stepEdge();
        checkAll("abort_accept", 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, '0, '0, '0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            stepEdge();
            checkAll("abort_read", 1'b1, abortBase + AW'(i), 1'b1, 1'b0, 1'b1, 1'b0);
        end
        rst_n = 1'b0;
        stepEdge();
        checkAll("abort", 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        idleCycles(2);
        runCommand(15'h0400, 15'd3, 8'd1, 0, -1, 1'b0);
        idleCycles(1);

        $display("[TB] randomized commands");
        for (int k = 0; k < 14; k++) begin
            runCommand(AW'($urandom), LW'($urandom_range(12)), RW'($urandom_range(4)),
                       30, -1, 1'($urandom));
            idleCycles(int'($urandom_range(2)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/activation_buffer_rd_sched.md
# activation_buffer_rd_sched

Read-sequencing controller for the activation buffer. It accepts a tile command (base address, tile length, repeat count) and issues one activation read per cycle. Reads run from `base` to `base+len-1`, and that sweep is repeated `rep` times. It drives the buffer's `activation_rd_en_i`/`buffer_rd_addr_i` inputs, which sit in front of the MAC array, and can be paused by downstream backpressure.

## Interface
- `BUFFER_ADDR_WIDTH`, 15: buffer address width; addresses wrap modulo 2^BUFFER_ADDR_WIDTH.
- `LEN_WIDTH`, 15: width of tile-length field.
- `REP_WIDTH`, 8: width of repeat-count field.

Ports:
- `clk`, in, 1: single clock, all logic on rising edge.
- `rst_n`, in, 1: synchronous, active-low reset.
- `start_i`, in, 1: command strobe; accepted only when idle (see Operation).
- `base_addr_i`, in, BUFFER_ADDR_WIDTH: tile start address, sampled with accepted start.
- `len_i`, in, LEN_WIDTH: reads per sweep, sampled with accepted start.
- `rep_i`, in, REP_WIDTH: number of sweeps, sampled with accepted start.
- `pause_i`, in, 1: backpressure; no read issued on an edge where it is 1.
- `activation_rd_en_o`, out, 1: registered read enable to buffer.
- `buffer_rd_addr_o`, out, BUFFER_ADDR_WIDTH: registered read address to buffer.
- `last_o`, out, 1: high with the final read of the command.
- `busy_o`, out, 1: command in progress.
- `done_o`, out, 1: one-cycle completion pulse.

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE.
- Reset values: all outputs 0; counters 0.
- IDLE, `start_i`=1 at an edge:
  - Latch `base`, `len`, `rep`; clear `idx` and `rep_cnt`; `busy_o`<=1.
  - If `len`=0 or `rep`=0 → DONE (no reads). Otherwise → RUN.
- IDLE, `start_i`=0: outputs hold 0.
- RUN, edge with `pause_i`=0:
  - `activation_rd_en_o`<=1; `buffer_rd_addr_o`<=base+idx (truncated to BUFFER_ADDR_WIDTH).
  - If idx=len-1: idx<=0, rep_cnt<=rep_cnt+1. Otherwise idx<=idx+1.
  - If this is read len*rep (idx=len-1 and rep_cnt=rep-1): `last_o`<=1, → DONE.
- RUN, edge with `pause_i`=1: `activation_rd_en_o`<=0, `last_o`<=0; address output and counters hold.
- DONE, any edge: `activation_rd_en_o`<=0, `last_o`<=0, `done_o`<=1, `busy_o`<=0, → IDLE.
- `done_o` is cleared on the following edge.
- `start_i` while RUN or DONE: ignored, no queuing.
- `start_i` during the `done_o` cycle: state is IDLE, so it is accepted (back-to-back commands).
- Address wrap: base+idx overflowing 2^BUFFER_ADDR_WIDTH wraps silently.
- `rst_n`=0 mid-command: at the next edge, abort, all outputs 0, IDLE; no `done_o`.

## Timing
- Start sampled at edge E0. First `activation_rd_en_o`=1 is visible after edge E1, provided `pause_i`=0 at E1.
- Unpaused, `rd_en` is high for exactly len*rep consecutive cycles after E1..E(len*rep).
- `done_o` is high the cycle after the last `rd_en` cycle. `busy_o` falls at that same edge.
- Each pause cycle adds exactly one cycle to total latency.
- Zero-length command: `busy_o` is high one cycle, then `done_o` pulses one cycle; both are relative to E0 (E1 and E2).
- Minimum command-to-command spacing: start in the `done_o` cycle; the next first read appears 2 edges later.

## Structure
- Shared package `abuf_sched_pkg`: state enum (IDLE/RUN/DONE) and default width constants.
- One natural sub-module: `abuf_addr_gen`.
  - Owns the idx/rep_cnt counters and the base+idx adder.
  - Outputs: `addr`, `sweep_end`, `cmd_end`.
  - Inputs: `load`, `advance`.
- The FSM and output registers stay in the top level.

## Test plan
- base=0x10, len=4, rep=2, pause=0 → addresses 0x10,11,12,13,10,11,12,13 on 8 consecutive cycles. `last_o` with the 8th. `done_o` 1 cycle later. `busy_o` high from E1 through the last read.
- Same command with `pause_i`=1 for 2 cycles after the 3rd read → `rd_en` low for 2 cycles. Address sequence unchanged. `done_o` is delayed by 2.
- base=0x7FFE, len=4, rep=1 → addresses 0x7FFE, 0x7FFF, 0x0000, 0x0001.
- len=0 (rep=3), then separately rep=0 (len=5) → no `rd_en`. `done_o` pulses at E2 for each.
- `start_i` held high during RUN with a different base → ignored. Restart in the `done_o` cycle → new sequence begins 2 edges later.
- `rst_n`=0 after the 2nd read of a len=8 command → all outputs 0 next cycle. No `done_o`. A fresh start afterwards runs normally.
